mux_2to1: RTL and testbench

Two-input, parameterizable-width selector with an optional registered output stage. The block forwards `a` when `s` is 0 and `b` when `s` is 1. It is a generic leaf cell used wherever a datapath picks between two sources. A synchronous, active-high reset clears the registered output path; the combinational configuration is a pure selector.

---
 rtl/mux_2to1.sv | 63 ++++++
 tb/tb_mux_2to1.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/mux_2to1.sv
// Two-input, WIDTH-bit selector: out = s ? b : a, either combinational or
// registered behind one clock stage. sel_out reports the select that produced out.
`timescale 1ns/1ps

module mux_2to1 #(
  parameter int WIDTH   = 1,
  parameter int OUT_REG = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             s,
  output logic [WIDTH-1:0] out,
  output logic             sel_out
);

  // The ternary merges a and b bitwise when s is X, so an unknown select
  // stays visible in simulation wherever the two sources disagree.
  function automatic logic [WIDTH-1:0] select2(
    input logic             sel,
    input logic [WIDTH-1:0] src0,
    input logic [WIDTH-1:0] src1
  );
    return sel ? src1 : src0;
  endfunction

  // ---- stage p0: combinational selection ----
  logic [WIDTH-1:0] sel_d_p0;
  logic             s_p0;

  assign sel_d_p0 = select2(s, a, b);
  assign s_p0     = s;

  generate
    if (OUT_REG != 0) begin : g_reg
      // ---- stage p1: registered output, cleared by reset ----
      logic [WIDTH-1:0] out_p1;
      logic             sel_p1;

      always_ff @(posedge clk) begin
        if (rst) begin
          out_p1 <= '0;
          sel_p1 <= 1'b0;
        end else begin
          out_p1 <= sel_d_p0;
          sel_p1 <= s_p0;
        end
      end

      assign out     = out_p1;
      assign sel_out = sel_p1;
    end else begin : g_comb
      // Clock and reset are intentionally unused in the pure selector.
      logic unused_clk_rst;
      assign unused_clk_rst = &{1'b0, clk, rst};

      assign out     = sel_d_p0;
      assign sel_out = s_p0;
    end
  endgenerate

endmodule

// File: tb/tb_mux_2to1.sv
// Scoreboard bench for mux_2to1: a combinational 1-bit instance and registered
// 8-bit and 64-bit instances, checked against a select/reset reference model.
`timescale 1ns/1ps

module tb_mux_2to1;

  logic clk = 1'b0;
  always #10 clk = ~clk;

  logic        rst;
  logic        ac, bc, sc, oc, soc;
  logic        s_r;
  logic [7:0]  a8, b8, o8;
  logic        so8;
  logic [63:0] a64, b64, o64;
  logic        so64;
  logic        glitch_en;

  mux_2to1 #(.WIDTH(1), .OUT_REG(0)) u_comb (
    .clk(clk), .rst(rst), .a(ac), .b(bc), .s(sc), .out(oc), .sel_out(soc));

  mux_2to1 #(.WIDTH(8), .OUT_REG(1)) u_reg8 (
    .clk(clk), .rst(rst), .a(a8), .b(b8), .s(s_r), .out(o8), .sel_out(so8));

  mux_2to1 #(.WIDTH(64), .OUT_REG(1)) u_reg64 (
    .clk(clk), .rst(rst), .a(a64), .b(b64), .s(s_r), .out(o64), .sel_out(so64));

  typedef struct {
    logic [63:0] d;
    logic        sel;
    string       tag;
  } exp_t;

  exp_t qc[$];
  exp_t q8[$];
  exp_t q64[$];

  int total = 0;
  int bad   = 0;

  task automatic compare(input string tag, input logic [63:0] got_d,
                         input logic got_s, input exp_t e);
    total++;
    if (got_d !== e.d || got_s !== e.sel) begin
      bad++;
      $display("FAIL %s/%s: got out=%h sel_out=%b, required out=%h sel_out=%b",
               tag, e.tag, got_d, got_s, e.d, e.sel);
    end
  endtask

  // Reference model: pick b when s is high, a otherwise; reset forces zero.
  function automatic exp_t model(input logic r, input logic sv,
                                 input logic [63:0] xa, input logic [63:0] xb,
                                 input string tag);
    exp_t e;
    e.d   = r ? 64'd0 : (sv ? xb : xa);
    e.sel = r ? 1'b0 : sv;
    e.tag = tag;
    return e;
  endfunction

  task automatic push_comb(input string tag);
    qc.push_back(model(1'b0, sc, {63'd0, ac}, {63'd0, bc}, tag));
  endtask

  task automatic step(input logic r, input logic sv, input logic [7:0] xa8,
                      input logic [7:0] xb8, input logic [63:0] xa64,
                      input logic [63:0] xb64, input string tag);
    @(negedge clk);
    rst = r; s_r = sv; a8 = xa8; b8 = xb8; a64 = xa64; b64 = xb64;
    q8.push_back(model(r, sv, {56'd0, xa8}, {56'd0, xb8}, tag));
    q64.push_back(model(r, sv, xa64, xb64, tag));
  endtask

  // Combinational monitor: settle half a nanosecond after each stimulus change.
  initial begin
    forever begin
      if (qc.size() == 0) begin
        #0.1;
      end else begin
        exp_t e;
        #0.5;
        e = qc.pop_front();
        compare("comb", {63'd0, oc}, soc, e);
      end
    end
  end

  // Registered monitor: one expected entry per edge, checked mid-cycle after
  // any glitch on the data inputs has had a chance to leak through.
  initial begin
    forever begin
      @(posedge clk);
      #7;
      if (q8.size() > 0) begin
        exp_t e;
        e = q8.pop_front();
        compare("reg8", {56'd0, o8}, so8, e);
      end
      if (q64.size() > 0) begin
        exp_t e;
        e = q64.pop_front();
        compare("reg64", o64, so64, e);
      end
    end
  end

  // Scramble data between edges; the registered outputs must not react.
  initial begin
    forever begin
      @(posedge clk);
      #3;
      if (glitch_en) begin
        a8  = 8'($urandom);
        b8  = 8'($urandom);
        a64 = {$urandom, $urandom};
        b64 = {$urandom, $urandom};
      end
    end
  end

  initial begin
    #100us;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; s_r = 1'b0; a8 = '0; b8 = '0; a64 = '0; b64 = '0;
    ac = 1'b0; bc = 1'b0; sc = 1'b0; glitch_en = 1'b0;

    // Combinational truth table
    for (int i = 0; i < 8; i++) begin
      logic [2:0] v;
      v = 3'(i);
      ac = v[0]; bc = v[1]; sc = v[2];
      push_comb("truth");
      #2;
    end

    // s toggles every 3 ns; a inverts 1 ns later, b 2 ns later
    for (int k = 0; k < 67; k++) begin
      sc = ~sc; push_comb("async_s"); #1;
      ac = ~ac; push_comb("async_a"); #1;
      bc = ~bc; push_comb("async_b"); #1;
    end

    glitch_en = 1'b1;

    // Reset held for two edges, then released with s=1
    step(1'b1, 1'b1, 8'hA5, 8'h3C, 64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, "rst_hold");
    step(1'b1, 1'b1, 8'hA5, 8'h3C, 64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, "rst_hold");
    step(1'b0, 1'b1, 8'hA5, 8'h3C, 64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, "rst_release");

    // One-cycle latency
    step(1'b0, 1'b0, 8'h11, 8'h99, 64'h11, 64'h99, "lat_a");
    step(1'b0, 1'b1, 8'h77, 8'h22, 64'h77, 64'h22, "lat_b");

    // Alternating stream with one reset edge in the middle
    for (int i = 0; i < 10; i++)
      step(i == 5, 1'(i), 8'hFF, 8'h0F, 64'hFF, 64'h0F, (i == 5) ? "mid_rst" : "mid_stream");

    // Wide path: all-ones vs all-zeros, s toggling every cycle
    for (int i = 0; i < 8; i++)
      step(1'b0, 1'(i), 8'($urandom), 8'($urandom), {64{1'b1}}, 64'd0, "wide");

    // Randomized traffic with occasional reset
    for (int i = 0; i < 40; i++)
      step($urandom_range(0, 7) == 0, 1'($urandom), 8'($urandom), 8'($urandom),
           {$urandom, $urandom}, {$urandom, $urandom}, "random");

    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 5 && (q8.size() + q64.size() + qc.size()) > 0; i++)
      @(posedge clk);
    #8;
    if (q8.size() + q64.size() + qc.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain: got %0d entries pending, required 0",
               q8.size() + q64.size() + qc.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
